// File: rtl/frame_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_loader_pkg
//  Description : Shared frame geometry defaults, the packed frame type used
//                by the network input, and the loader write-FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_loader_pkg;

  localparam int DEF_INPUT_SIZE     = 16;
  localparam int DEF_INPUT_CHANNELS = 1;
  localparam int DEF_PX_SIZE        = 8;

  // Packed frame, identical in layout to the network img_in bus:
  // [row][col][channel][bit], sample [0][0][0] in the least significant bits.
  typedef logic [DEF_INPUT_SIZE-1:0][DEF_INPUT_SIZE-1:0]
                [DEF_INPUT_CHANNELS-1:0][DEF_PX_SIZE-1:0] frame_t;

  // Write-side state: FILL stores samples, DISCARD swallows the tail of an
  // over-long frame until its s_last.
  typedef enum logic [0:0] {
    ST_FILL    = 1'b0,
    ST_DISCARD = 1'b1
  } wr_state_t;

endpackage : frame_loader_pkg
`default_nettype wire

// File: rtl/frame_loader_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buffer
//  Description : One frame of sample storage. A single sample is written per
//                cycle at index idx; the whole frame is always visible on
//                the flat frame output (sample k at bits [k*PX_SIZE +: PX_SIZE]).
//  Ports       : clk, rst (async, active high, clears contents)
//                we, idx, din  - sample write port
//                frame         - complete frame contents
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer
  import frame_loader_pkg::*;
#(
  parameter int N       = DEF_INPUT_SIZE * DEF_INPUT_SIZE * DEF_INPUT_CHANNELS,
  parameter int PX_SIZE = DEF_PX_SIZE,
  parameter int CNT_W   = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [CNT_W-1:0]     idx,
  input  logic [PX_SIZE-1:0]   din,
  output logic [N*PX_SIZE-1:0] frame
);

  logic [N-1:0][PX_SIZE-1:0] r_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
    end else if (we) begin
      r_mem[idx] <= din;
    end
  end

  assign frame = r_mem;

endmodule : frame_buffer
`default_nettype wire

// File: rtl/frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : frame_loader
//  Description : Assembles a raster sample stream into complete frames in a
//                ping-pong pair of buffers. One buffer is presented stable to
//                the network while the other loads. Frames whose length does
//                not agree with s_last are dropped and counted.
//  Ports       : clk, rst (async, active high)
//                s_valid/s_ready/s_data/s_last - sample stream in
//                m_valid/m_ready/frame_out     - frame handoff out
//                err_len  - one-cycle pulse per dropped frame
//                drop_cnt - saturating dropped-frame count
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_loader
  import frame_loader_pkg::*;
#(
  parameter int INPUT_SIZE     = DEF_INPUT_SIZE,
  parameter int INPUT_CHANNELS = DEF_INPUT_CHANNELS,
  parameter int PX_SIZE        = DEF_PX_SIZE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [PX_SIZE-1:0] s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] frame_out,
  output logic               err_len,
  output logic [7:0]         drop_cnt
);

  localparam int N     = INPUT_SIZE * INPUT_SIZE * INPUT_CHANNELS;
  localparam int CNT_W = $clog2(N);

  wr_state_t          r_state;
  wr_state_t          w_state_nxt;
  logic [CNT_W-1:0]   r_wr_cnt;
  logic               r_wr_sel;
  logic               r_rd_sel;
  logic [1:0]         r_full;
  logic               r_err_len;
  logic [7:0]         r_drop_cnt;

  logic               w_xfer;
  logic               w_handoff;
  logic               w_at_end;
  logic               w_we;
  logic               w_commit;
  logic               w_drop;
  logic [1:0]         w_set;
  logic [1:0]         w_clr;
  logic [N*PX_SIZE-1:0] w_buf_frame [2];

  assign w_xfer    = s_valid && s_ready;
  assign w_handoff = m_valid && m_ready;
  assign w_at_end  = (r_wr_cnt == CNT_W'(N - 1));

  // --------------------------------------------------------------------------
  // Write FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Write FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL:    if (w_xfer && w_at_end && !s_last) w_state_nxt = ST_DISCARD;
      ST_DISCARD: if (w_xfer && s_last)              w_state_nxt = ST_FILL;
      default:    w_state_nxt = ST_FILL;
    endcase
  end

  // --------------------------------------------------------------------------
  // Write FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    // DISCARD always accepts so a long frame's tail can never deadlock.
    s_ready  = !rst && ((r_state == ST_DISCARD) || !r_full[r_wr_sel]);
    w_we     = w_xfer && (r_state == ST_FILL);
    w_commit = w_we && s_last && w_at_end;
    // Short frame (early s_last) or long frame (no s_last at the final slot).
    w_drop   = w_we && (s_last != w_at_end);
    w_set    = 2'b00;
    w_clr    = 2'b00;
    if (w_commit)  w_set[r_wr_sel] = 1'b1;
    if (w_handoff) w_clr[r_rd_sel] = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Counters, buffer status and select registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt   <= '0;
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_full     <= 2'b00;
      r_err_len  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_we) begin
        r_wr_cnt <= (s_last || w_at_end) ? '0 : r_wr_cnt + 1'b1;
      end
      // Commit and handoff always target different buffers, so both apply.
      r_full    <= (r_full | w_set) & ~w_clr;
      if (w_commit)  r_wr_sel <= ~r_wr_sel;
      if (w_handoff) r_rd_sel <= ~r_rd_sel;
      r_err_len <= w_drop;
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Ping-pong buffers
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < 2; b++) begin : g_buf
    frame_buffer #(
      .N       (N),
      .PX_SIZE (PX_SIZE),
      .CNT_W   (CNT_W)
    ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (w_we && (r_wr_sel == 1'(b))),
      .idx   (r_wr_cnt),
      .din   (s_data),
      .frame (w_buf_frame[b])
    );
  end

  assign m_valid   = r_full[r_rd_sel];
  assign frame_out = r_rd_sel ? w_buf_frame[1] : w_buf_frame[0];
  assign err_len   = r_err_len;
  assign drop_cnt  = r_drop_cnt;

endmodule : frame_loader
`default_nettype wire

// File: tb/tb_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_loader
//  Description : Self-checking bench for frame_loader. Expected frames are
//                queued when a well-formed frame is driven and compared when
//                the loader hands a frame off.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_loader;
  import frame_loader_pkg::*;

  localparam int S = DEF_INPUT_SIZE;
  localparam int C = DEF_INPUT_CHANNELS;
  localparam int N = S * S * C;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  frame_t     frame_out;
  logic       err_len;
  logic [7:0] drop_cnt;

  frame_t exp_q[$];
  int     n_checks     = 0;
  int     n_err        = 0;
  int     acc_cnt      = 0;
  int     err_pulses   = 0;
  int     err_at       = -1;
  int     handoffs     = 0;
  int     stall_cycles = 0;
  frame_t prev_frame;
  bit     prev_hold    = 1'b0;

  frame_loader dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_out (frame_out),
    .err_len   (err_len),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic finish_tb();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  endtask

  // Reference frame: sample k carries (k + seed) mod 256.
  function automatic frame_t make_frame(input int seed);
    frame_t f = '0;
    for (int k = 0; k < N; k++) begin
      f[k / (S * C)][(k / C) % S][k % C] = 8'(k + seed);
    end
    return f;
  endfunction

  function automatic int diff_count(input frame_t a, input frame_t b);
    int d = 0;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++)
        for (int h = 0; h < C; h++)
          if (a[r][c][h] !== b[r][c][h]) d++;
    return d;
  endfunction

  // Monitor: handoff scoreboard, hold stability, event counters.
  initial begin
    frame_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_hold) chk("hold_stable_diffs", 64'(diff_count(frame_out, prev_frame)), 64'd0);
        if (err_len) begin
          err_pulses++;
          err_at = acc_cnt;
        end
        if (m_valid && m_ready) begin
          handoffs++;
          if (exp_q.size() == 0) begin
            chk("sb_size_at_handoff", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            chk("handoff_frame_diffs", 64'(diff_count(frame_out, e)), 64'd0);
          end
        end
        if (s_valid && s_ready)  acc_cnt++;
        if (s_valid && !s_ready) stall_cycles++;
      end
      prev_hold  = !rst && m_valid && !m_ready;
      prev_frame = frame_out;
    end
  end

  task automatic wait_accept();
    int t = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 3000) begin
        chk("accept_timeout", 64'(t), 64'd0);
        finish_tb();
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Drives len samples; s_last on sample last_idx (-1 for none). s_valid is
  // left high so consecutive calls stream without bubbles.
  task automatic send_frame(input int len, input int last_idx, input int seed, input bit push);
    if (push) exp_q.push_back(make_frame(seed));
    for (int k = 0; k < len; k++) begin
      s_valid = 1'b1;
      s_data  = 8'(k + seed);
      s_last  = (k == last_idx);
      wait_accept();
    end
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain_one();
    int t = 0;
    forever begin
      @(negedge clk);
      if (m_valid) break;
      t++;
      if (t > 3000) begin
        chk("m_valid_timeout", 64'(t), 64'd0);
        finish_tb();
      end
    end
    @(posedge clk); #1 m_ready = 1'b1;
    @(posedge clk); #1 m_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    n_err++;
    finish_tb();
  end

  initial begin
    int e0, a0, h0, st0;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid",  64'(m_valid), 64'd0);
    chk("rst_s_ready",  64'(s_ready), 64'd0);
    chk("rst_err_len",  64'(err_len), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_frame_diffs", 64'(diff_count(frame_out, '0)), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", 64'(s_ready), 64'd1);

    // Single frame, consumer idle
    @(posedge clk); #1;
    send_frame(N, N - 1, 0, 1'b1);
    idle();
    @(negedge clk);
    chk("t1_m_valid", 64'(m_valid), 64'd1);
    chk("t1_px_0_0",   64'(frame_out[0][0][0]), 64'h00);
    chk("t1_px_0_1",   64'(frame_out[0][1][0]), 64'h01);
    chk("t1_px_15_15", 64'(frame_out[15][15][0]), 64'hFF);
    chk("t1_err_pulses", 64'(err_pulses), 64'd0);
    drain_one();
    chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure with both buffers full
    h0 = handoffs;
    send_frame(N, N - 1, 1, 1'b1);
    send_frame(N, N - 1, 2, 1'b1);
    idle();
    @(negedge clk);
    chk("t2_s_ready_full", 64'(s_ready), 64'd0);
    chk("t2_m_valid", 64'(m_valid), 64'd1);
    @(posedge clk); #1;
    fork
      send_frame(N, N - 1, 3, 1'b1);
      begin
        repeat (6) @(posedge clk);
        #1 m_ready = 1'b1;
        @(posedge clk); #1 m_ready = 1'b0;
      end
    join
    idle();
    drain_one();
    drain_one();
    chk("t2_handoffs", 64'(handoffs - h0), 64'd3);
    chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // Short frame
    e0 = err_pulses;
    send_frame(100, 99, 10, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    chk("t3_err_pulses", 64'(err_pulses - e0), 64'd1);
    chk("t3_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("t3_m_valid", 64'(m_valid), 64'd0);
    @(posedge clk); #1;
    send_frame(N, N - 1, 20, 1'b1);
    idle();
    drain_one();
    chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // Long frame
    e0 = err_pulses;
    a0 = acc_cnt;
    send_frame(300, 299, 30, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    chk("t4_err_pulses", 64'(err_pulses - e0), 64'd1);
    chk("t4_err_at_accept", 64'(err_at - a0), 64'd256);
    chk("t4_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("t4_m_valid", 64'(m_valid), 64'd0);
    @(posedge clk); #1;
    send_frame(N, N - 1, 40, 1'b1);
    idle();
    drain_one();
    chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);

    // Continuous streaming with a consumer that always keeps up
    h0  = handoffs;
    st0 = stall_cycles;
    m_ready = 1'b1;
    send_frame(N, N - 1, 50, 1'b1);
    send_frame(N, N - 1, 60, 1'b1);
    send_frame(N, N - 1, 70, 1'b1);
    idle();
    repeat (3) @(posedge clk);
    #1 m_ready = 1'b0;
    chk("t5_handoffs", 64'(handoffs - h0), 64'd3);
    chk("t5_stalls", 64'(stall_cycles - st0), 64'd0);
    chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);

    // drop_cnt saturation via one-sample frames
    e0 = err_pulses;
    for (int i = 0; i < 260; i++) send_frame(1, 0, i, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    chk("t6_err_pulses", 64'(err_pulses - e0), 64'd260);
    chk("t6_drop_sat", 64'(drop_cnt), 64'd255);

    // Asynchronous reset mid-frame while a full frame is presented
    @(posedge clk); #1;
    send_frame(N, N - 1, 80, 1'b0);
    send_frame(128, -1, 90, 1'b0);
    chk("t7_pre_m_valid", 64'(m_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_m_valid",  64'(m_valid), 64'd0);
    chk("t7_rst_s_ready",  64'(s_ready), 64'd0);
    chk("t7_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("t7_rst_frame_diffs", 64'(diff_count(frame_out, '0)), 64'd0);
    idle();
    e0 = err_pulses;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send_frame(N, N - 1, 100, 1'b1);
    idle();
    drain_one();
    chk("t7_err_pulses", 64'(err_pulses - e0), 64'd0);
    chk("t7_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("t7_sb_empty", 64'(exp_q.size()), 64'd0);

    repeat (2) @(posedge clk);
    finish_tb();
  end

endmodule : tb_frame_loader
`default_nettype wire

// File: doc/frame_loader.md
Name: frame_loader

Overview:
- Upstream stage of minimobilenet. Accepts a raster pixel stream over a valid/ready handshake and assembles complete INPUT_SIZE x INPUT_SIZE x INPUT_CHANNELS frames.
- Presents each frame as the packed img_in bus the network consumes.
- Ping-pong double buffer: one frame is held stable for the network while the next one loads.
- Malformed frames are detected by length checking against s_last, then dropped.

Parameters:
- INPUT_SIZE, 16, frame width and height (square).
- INPUT_CHANNELS, 1, channels per pixel location.
- PX_SIZE, 8, bits per channel sample.
- Derived localparam N = INPUT_SIZE*INPUT_SIZE*INPUT_CHANNELS (samples per frame). CNT_W = $clog2(N).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  loader can accept a sample.
- s_data  in  PX_SIZE  sample value.
- s_last  in  1  marks final sample of a frame.
- m_valid  out  1  frame_out holds a complete frame.
- m_ready  in  1  consumer has latched or finished with the frame.
- frame_out  out  [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0]  packed frame, same layout as the network img_in.
- err_len  out  1  one-cycle pulse when a frame is dropped for a length mismatch.
- drop_cnt  out  8  saturating count of dropped frames.

Behaviour:
- Sample ordering:
  - Sample k (0-based) is written to frame[row][col][ch], where k = (row*INPUT_SIZE + col)*INPUT_CHANNELS + ch.
  - Channel is innermost, then column, then row. The first sample lands at [0][0][0].
- A transfer occurs when s_valid && s_ready. A handoff occurs when m_valid && m_ready.
- Buffers:
  - Two buffers, each with a status of FREE or FULL.
  - wr_sel is the buffer being written; rd_sel is the buffer being presented.
- Write FSM states: FILL and DISCARD.
  - FILL: each transfer writes buf[wr_sel][k] and increments wr_cnt.
    - Transfer with wr_cnt==N-1 and s_last=1: buffer goes FULL, wr_sel toggles, wr_cnt=0.
    - Transfer with s_last=1 and wr_cnt<N-1 (short frame): wr_cnt=0, buffer stays FREE, err_len pulses, drop_cnt increments, state stays FILL.
    - Transfer with wr_cnt==N-1 and s_last=0 (long frame): wr_cnt=0, err_len pulses, drop_cnt increments, state goes to DISCARD.
  - DISCARD: every transfer is accepted and ignored. A transfer with s_last=1 returns the FSM to FILL with wr_cnt=0. No further err_len pulse for the same frame.
- s_ready:
  - s_ready = !rst && (state==DISCARD || buf[wr_sel] FREE).
  - Backpressure applies only when both buffers are FULL.
- Read side:
  - m_valid = buf[rd_sel] FULL.
  - frame_out = buf[rd_sel], combinationally, always.
  - frame_out must not change while m_valid=1 and no handoff has occurred.
  - Handoff: buf[rd_sel] goes FREE and rd_sel toggles.
- Latency: final sample accepted at edge t; m_valid is high after edge t (visible in cycle t+1). Zero bubbles between back-to-back frames when the consumer keeps up.
- Simultaneous commit and handoff in one cycle: both take effect. Sustained throughput is one sample per cycle.
- m_ready while m_valid=0: ignored.
- drop_cnt saturates at 255.
- Reset (async, any time, including mid-frame):
  - Both buffers FREE and contents cleared to 0.
  - wr_sel=rd_sel=0, wr_cnt=0, state FILL.
  - m_valid=0, s_ready=0 while rst is high, err_len=0, drop_cnt=0, frame_out=0.
  - A partial frame in progress is discarded silently, with no err_len.

Decomposition:
- Shared package (e.g. mmnet_pkg):
  - INPUT_SIZE, INPUT_CHANNELS, PX_SIZE defaults.
  - Frame typedef frame_t = logic [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0], reused by minimobilenet.
- One natural sub-module, frame_buffer: a single buffer with write enable, sample index, data in, and full frame out. Instantiated twice.
- Top level holds the FSM, counters, and select logic.

Test Plan (defaults, N=256):
- Reset, then 256 samples with value k&0xFF, s_last on k=255, m_ready=0:
  - m_valid rises the cycle after the last accept.
  - frame_out[0][0][0]=0x00, frame_out[0][1][0]=0x01, frame_out[15][15][0]=0xFF.
  - err_len never pulses.
- m_ready=0 throughout, three frames streamed:
  - Two frames are accepted.
  - s_ready=0 from the cycle after the 512th accept.
  - Pulsing m_ready once frees a buffer, s_ready returns to 1, and the third frame completes.
  - Frames emerge in order; frame 2's data is unchanged until its handoff.
- Short frame: s_last on sample 99:
  - err_len pulses once, drop_cnt=1, m_valid stays 0.
  - A following correct frame is delivered intact.
- Long frame: 300 samples, s_last on sample 299:
  - err_len pulses at the 256th accept, samples 256..299 are discarded, drop_cnt=1.
  - The next 256-sample frame is delivered correctly.
- Continuous stream with m_ready=1 and s_valid=1:
  - No s_ready deassertion.
  - One m_valid handoff per 256 cycles, data matches.
- Assert rst at sample 128 of frame 2 while frame 1 is FULL:
  - m_valid, s_ready, drop_cnt and frame_out go to 0 immediately.
  - A post-reset frame is delivered correctly with no err_len.
